// File: rtl/prio2bin_seq.sv
// prio2bin_seq: serialises a request bitmap into a stream of set-bit indices, highest first.
module prio2bin_seq #(
  parameter int DW = 64,
  parameter int AW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          busy
);
  logic          r_busy;
  logic [DW-1:0] r_pending;
  logic [AW-1:0] w_idx;
  logic [DW-1:0] w_rest;
  logic          w_last;
  logic          w_hs;
  logic          w_acc;
  // Ascending scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DW; i++)
      if (r_pending[i]) w_idx = AW'(i);
  end
  assign w_rest    = r_pending & ~(DW'(1) << w_idx);
  assign w_last    = r_busy && (w_rest == '0);
  assign w_hs      = r_busy && out_ready;
  assign in_ready  = !clear && (!r_busy || (w_hs && w_last));
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_busy;
  assign out_index = r_busy ? w_idx : '0;
  assign out_last  = w_last;
  assign busy      = r_busy;
  // An accepted all-zero vector falls through to the handshake branch, retiring the last index.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_busy    <= 1'b0;
      r_pending <= '0;
    end else if (clear) begin
      r_busy    <= 1'b0;
      r_pending <= '0;
    end else if (w_acc && |in) begin
      r_busy    <= 1'b1;
      r_pending <= in;
    end else if (w_hs) begin
      r_busy    <= !w_last;
      r_pending <= w_rest;
    end
  end
endmodule
